tick_bank: RTL and testbench

- Multi-channel, runtime-programmable tick generator. Next generation of the fixed-period clock-enable divider.
- Each of CHANNELS independent counters emits a registered one-cycle tick every (top+1) clk cycles, in periodic or one-shot mode.
- Serves as the common timebase for game logic (ball step, paddle poll, frame timers, debounce). Ticks are clock enables, never clocks.

---
 rtl/tick_bank_pkg.sv | 14 +
 rtl/tick_channel.sv | 78 +++++++
 rtl/tick_bank.sv | 45 ++++
 tb/tb_tick_bank.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/tick_bank_pkg.sv
// Shared types and helpers for the tick_bank multi-channel tick generator.
package tick_bank_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  // Selector width, never narrower than one bit so a single-channel bank still has a port.
  function automatic int sel_width(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick slice: programmable top value, periodic or one-shot, registered tick/busy.
//
//   state | meaning
//   IDLE  | counter held at 0, no ticks, busy low
//   RUN   | counting 0..top, tick on the cycle after counter reaches top
module tick_channel
  import tick_bank_pkg::*;
#(
  parameter int               WIDTH         = 16,
  parameter logic [WIDTH-1:0] DEFAULT_TOP   = WIDTH'(12000),
  parameter bit               RESET_RUN_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_top,
  input  logic             load_enable,
  input  logic             load_oneshot,
  input  logic             restart,
  output logic             tick,
  output logic             busy
);

  ch_state_t        state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] top;
  logic             oneshot;

  always_ff @(posedge clk) begin
    if (reset) begin
      top     <= DEFAULT_TOP;
      count   <= '0;
      oneshot <= 1'b0;
      state   <= RESET_RUN_BIT ? RUN : IDLE;
      tick    <= 1'b0;
      busy    <= RESET_RUN_BIT;
    end else if (load) begin
      // A write wins over an expiry on the same edge, so no tick escapes.
      top     <= load_top;
      oneshot <= load_oneshot;
      count   <= '0;
      tick    <= 1'b0;
      state   <= load_enable ? RUN : IDLE;
      busy    <= load_enable;
    end else if (restart && (state == RUN)) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          tick  <= 1'b0;
          busy  <= 1'b0;
        end
        RUN: begin
          if (count == top) begin
            count <= '0;
            tick  <= 1'b1;
            if (oneshot) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            count <= count + WIDTH'(1);
            tick  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
          tick  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tick_bank.sv
// Bank of independent tick channels sharing one config port and a global phase restart.
module tick_bank
  import tick_bank_pkg::*;
#(
  parameter int                  CHANNELS    = 4,
  parameter int                  WIDTH       = 16,
  parameter int unsigned         DEFAULT_TOP = 12000,
  parameter logic [CHANNELS-1:0] RESET_RUN   = CHANNELS'(1),
  localparam int                 SELW        = sel_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [SELW-1:0]     cfg_sel,
  input  logic [WIDTH-1:0]    cfg_top,
  input  logic                cfg_enable,
  input  logic                cfg_oneshot,
  input  logic                sync_restart,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] busy
);

  // Out-of-range selectors match no channel index, so such writes fall on the floor.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic load;
    assign load = cfg_we && (cfg_sel == SELW'(i));

    tick_channel #(
      .WIDTH         (WIDTH),
      .DEFAULT_TOP   (WIDTH'(DEFAULT_TOP)),
      .RESET_RUN_BIT (RESET_RUN[i])
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .load         (load),
      .load_top     (cfg_top),
      .load_enable  (cfg_enable),
      .load_oneshot (cfg_oneshot),
      .restart      (sync_restart),
      .tick         (tick[i]),
      .busy         (busy[i])
    );
  end

endmodule

// File: tb/tb_tick_bank.sv
// Directed bench for tick_bank: a 4-channel bank plus a 3-channel bank for the out-of-range selector.
module tb_tick_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [15:0] cfg_top = '0;
  logic        cfg_enable = 1'b0;
  logic        cfg_oneshot = 1'b0;
  logic        sync_restart = 1'b0;
  logic [3:0]  tick, busy;
  logic [2:0]  tick3, busy3;

  int total = 0;
  int bad = 0;
  int seen;

  always #5 clk = ~clk;

  tick_bank #(
    .CHANNELS(4), .WIDTH(16), .DEFAULT_TOP(3), .RESET_RUN(4'b0001)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_top(cfg_top),
    .cfg_enable(cfg_enable), .cfg_oneshot(cfg_oneshot), .sync_restart(sync_restart),
    .tick(tick), .busy(busy)
  );

  tick_bank #(
    .CHANNELS(3), .WIDTH(16), .DEFAULT_TOP(3), .RESET_RUN(3'b001)
  ) dut3 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_top(cfg_top),
    .cfg_enable(cfg_enable), .cfg_oneshot(cfg_oneshot), .sync_restart(sync_restart),
    .tick(tick3), .busy(busy3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset defaults
    repeat (3) step();
    check("rst_tick", 16'(tick), 16'h0);
    check("rst_busy", 16'(busy), 16'h1);
    check("rst_busy3", 16'(busy3), 16'h1);
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("def_tick", 16'(tick), (k % 4 == 0) ? 16'h1 : 16'h0);
      check("def_busy", 16'(busy), 16'h1);
    end
    check("def_tick3", 16'(tick3), 16'h1);

    // One-shot on ch2, top=5
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_top = 16'd5; cfg_enable = 1'b1; cfg_oneshot = 1'b1;
    step();
    cfg_we = 1'b0;
    check("os_busy_e0", 16'(busy[2]), 16'h1);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("os_tick", 16'(tick[2]), (k == 6) ? 16'h1 : 16'h0);
      check("os_busy", 16'(busy[2]), (k == 6) ? 16'h0 : 16'h1);
    end
    seen = 0;
    repeat (50) begin
      step();
      if (tick[2] || busy[2]) seen++;
    end
    check("os_quiet", 16'(seen), 16'h0);

    // Ch1 periodic top=9, rewritten to top=2 on the expiry edge
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_top = 16'd9; cfg_enable = 1'b1; cfg_oneshot = 1'b0;
    step();
    cfg_we = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      check("p9_tick", 16'(tick[1]), 16'h0);
    end
    cfg_we = 1'b1; cfg_top = 16'd2;
    step();
    cfg_we = 1'b0;
    check("ovr_tick", 16'(tick[1]), 16'h0);
    check("ovr_busy", 16'(busy[1]), 16'h1);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("p2_tick", 16'(tick[1]), (k % 3 == 0) ? 16'h1 : 16'h0);
    end

    // Offset-phase ch0 top=7, ch1 top=3, then sync_restart
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_top = 16'd7; cfg_enable = 1'b1; cfg_oneshot = 1'b0;
    step();
    cfg_we = 1'b0;
    repeat (2) step();
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_top = 16'd3;
    step();
    cfg_we = 1'b0;
    repeat (5) step();
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    check("sr_tick", 16'(tick), 16'h0);
    check("sr_busy", 16'(busy), 16'h3);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("sr_phase", 16'(tick), (k == 8) ? 16'h3 : ((k == 4) ? 16'h2 : 16'h0));
    end
    check("sr_phase3", 16'(tick3), 16'h3);

    // Disable ch0, then selector 3: ch3 on the 4-channel bank, ignored on the 3-channel bank
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_enable = 1'b0;
    step();
    cfg_we = 1'b0;
    check("dis_tick0", 16'(tick[0]), 16'h0);
    check("dis_busy", 16'(busy), 16'h2);
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_top = 16'd0; cfg_enable = 1'b1; cfg_oneshot = 1'b0;
    step();
    cfg_we = 1'b0;
    check("badsel_busy3", 16'(busy3), 16'h2);
    check("badsel_tick3", 16'(tick3), 16'h0);
    check("ch3_busy", 16'(busy), 16'ha);
    check("ch3_tick", 16'(tick), 16'h0);
    step();
    check("ch3_cont", 16'(tick), 16'h8);
    check("badsel_tick3b", 16'(tick3), 16'h0);
    step();
    check("ch1_and_ch3", 16'(tick), 16'ha);
    check("badsel_tick3c", 16'(tick3), 16'h2);

    // Reset mid-period
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_tick", 16'(tick), 16'h0);
    check("rst2_busy", 16'(busy), 16'h1);
    check("rst2_tick3", 16'(tick3), 16'h0);
    check("rst2_busy3", 16'(busy3), 16'h1);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("rst2_first", 16'(tick), (k == 4) ? 16'h1 : 16'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
